// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port: one registered write strobe with its byte address and data.
interface uart_program_loader_if;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: UART 8N1 receiver feeding a length-prefixed little-endian word writer into instruction memory.
// Holds the core in reset until the last word is written; the serial line is ignored afterwards.
module uart_program_loader #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    uart_program_loader_if.master         imem,
    output logic                          core_rst,
    output logic                          done,
    output logic                          err
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} l_state_t;

    logic rxd_s1, rxd_s;
    rx_state_t rx_state, rx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic [7:0] sh, sh_nxt;
    logic byte_vld, bv_nxt, ferr;

    l_state_t l_state, l_nxt;
    logic [1:0] pos, pos_nxt;
    logic [31:0] len, len_nxt, word, word_nxt;
    logic [29:0] idx, idx_nxt;
    logic we_nxt;
    logic [31:0] addr_nxt, wdata_nxt;
    logic err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1          <= 1'b1;
            rxd_s           <= 1'b1;
            rx_state        <= RX_IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            sh              <= '0;
            byte_vld        <= 1'b0;
            l_state         <= L_LEN;
            pos             <= '0;
            len             <= '0;
            word            <= '0;
            idx             <= '0;
            imem.imem_we    <= 1'b0;
            imem.imem_addr  <= '0;
            imem.imem_wdata <= '0;
            err             <= 1'b0;
        end else begin
            rxd_s1          <= rxd;
            rxd_s           <= rxd_s1;
            rx_state        <= rx_nxt;
            cnt             <= cnt_nxt;
            bit_cnt         <= bit_nxt;
            sh              <= sh_nxt;
            byte_vld        <= bv_nxt;
            l_state         <= l_nxt;
            pos             <= pos_nxt;
            len             <= len_nxt;
            word            <= word_nxt;
            idx             <= idx_nxt;
            imem.imem_we    <= we_nxt;
            imem.imem_addr  <= addr_nxt;
            imem.imem_wdata <= wdata_nxt;
            err             <= err_nxt;
        end
    end

    // Receiver: mid-bit sampling, timed from the detected falling edge of the start bit.
    always_comb begin
        rx_nxt  = rx_state;
        cnt_nxt = cnt;
        bit_nxt = bit_cnt;
        sh_nxt  = sh;
        bv_nxt  = 1'b0;
        ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxd_s) begin
                    cnt_nxt = HALF;
                    rx_nxt  = RX_START;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (!rxd_s) begin
                        rx_nxt  = RX_DATA;
                        cnt_nxt = FULL;
                        bit_nxt = '0;
                    end else begin
                        rx_nxt = RX_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    sh_nxt  = {rxd_s, sh[7:1]};
                    cnt_nxt = FULL;
                    bit_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_nxt = RX_STOP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    rx_nxt = RX_IDLE;
                    if (rxd_s) bv_nxt = 1'b1;
                    else       ferr   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // Loader: done is entered one cycle after the final write strobe, so the strobe and done never overlap.
    always_comb begin
        l_nxt     = l_state;
        pos_nxt   = pos;
        len_nxt   = len;
        word_nxt  = word;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        addr_nxt  = imem.imem_addr;
        wdata_nxt = imem.imem_wdata;
        err_nxt   = err | (ferr && (l_state != L_DONE));
        case (l_state)
            L_LEN: begin
                if (byte_vld) begin
                    len_nxt = {sh, len[31:8]};
                    pos_nxt = pos + 2'd1;
                    if (pos == 2'd3) l_nxt = (len_nxt != '0) ? L_DATA : L_DONE;
                end
            end
            L_DATA: begin
                if (imem.imem_we && ({2'b00, idx} == len)) begin
                    l_nxt = L_DONE;
                end else if (byte_vld) begin
                    word_nxt = {sh, word[31:8]};
                    pos_nxt  = pos + 2'd1;
                    if (pos == 2'd3) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = {idx, 2'b00};
                        wdata_nxt = word_nxt;
                        idx_nxt   = idx + 30'd1;
                    end
                end
            end
            default: l_nxt = L_DONE;
        endcase
    end

    assign done     = (l_state == L_DONE);
    assign core_rst = ~done;
endmodule
